fir_uart_sequencer: RTL and testbench



---
 rtl/fir_uart_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_fir_uart_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_uart_sequencer.sv
// fir_uart_sequencer: glue between the UART receiver/transmitter pair and the FIR filter.
// Received byte pairs (low byte first) become 16-bit FIR samples. FIR results are sliced
// to 16 bits and queued in a small word FIFO. Queued words are sent back as two bytes,
// low byte first.
// Optional build macro FIR_SEQ_SAT_EN: the 16-bit slice saturates (signed) instead of
// truncating.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_ready, rx_data           received byte strobe and data
//   fir_in_valid, fir_in_data   assembled sample {hi,lo} to the FIR
//   fir_out_valid, fir_out_data FIR result strobe and data
//   tx_busy, tx_start, tx_data  transmitter handshake and byte
//   ovf, rx_err                 sticky drop / receive-timeout flags
//   fifo_level, last_word       queued word count, last fully transmitted word
module fir_uart_sequencer #(
  parameter int unsigned OUT_W      = 38,
  parameter int unsigned SLICE_LSB  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RX_TIMEOUT = 5000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  output logic                          fir_in_valid,
  output logic [15:0]                   fir_in_data,
  input  logic                          fir_out_valid,
  input  logic [OUT_W-1:0]              fir_out_data,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic                          ovf,
  output logic                          rx_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   last_word
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int unsigned TOP   = SLICE_LSB + 15;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RX_TIMEOUT - 1);

  typedef enum logic {RX_LO, RX_HI} rx_state_e;
  typedef enum logic [2:0] {
    TX_IDLE, TX_LO, TX_GAP_LO, TX_WAIT_LO, TX_HI, TX_GAP_HI, TX_WAIT_HI
  } tx_state_e;

  // Receive side state
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       lo_q, lo_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fir_in_valid_q, fir_in_valid_d;
  logic [15:0]      fir_in_data_q, fir_in_data_d;
  logic             rx_err_q, rx_err_d;

  // Transmit side state
  tx_state_e        tx_state_q, tx_state_d;
  logic [15:0]      word_q, word_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [15:0]      last_word_q, last_word_d;

  // Word FIFO
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             push_c, pop_c, full_c;
  logic [15:0]      slice_c;
  logic             unused_fir_bits;

  // Bits outside the slice window only matter to the saturating build.
  assign unused_fir_bits = ^fir_out_data;

`ifdef FIR_SEQ_SAT_EN
  // In range only when every bit from the slice MSB upward matches the sign.
  logic [OUT_W-1-TOP:0] upper_c;
  assign upper_c = fir_out_data[OUT_W-1:TOP];
  always_comb begin
    if ((upper_c == '0) || (upper_c == '1)) slice_c = fir_out_data[TOP:SLICE_LSB];
    else if (fir_out_data[OUT_W-1])          slice_c = 16'h8000;
    else                                     slice_c = 16'h7FFF;
  end
`else
  assign slice_c = fir_out_data[TOP:SLICE_LSB];
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign full_c = (level_q == FULL_LVL);
  assign push_c = fir_out_valid && (!full_c || pop_c);

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q | (fir_out_valid & full_c & ~pop_c);
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array needs no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= slice_c;
  end

  // Receive FSM: pair bytes into samples, abandon a lone low byte after the timeout.
  always_comb begin
    rx_state_d     = rx_state_q;
    lo_d           = lo_q;
    tmo_d          = tmo_q;
    fir_in_valid_d = 1'b0;
    fir_in_data_d  = fir_in_data_q;
    rx_err_d       = rx_err_q;
    case (rx_state_q)
      RX_LO: begin
        if (rx_ready) begin
          lo_d       = rx_data;
          tmo_d      = '0;
          rx_state_d = RX_HI;
        end
      end
      RX_HI: begin
        if (rx_ready) begin
          fir_in_valid_d = 1'b1;
          fir_in_data_d  = {rx_data, lo_q};
          rx_state_d     = RX_LO;
        end else if (tmo_q == TMO_LAST) begin
          rx_err_d   = 1'b1;
          rx_state_d = RX_LO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: rx_state_d = RX_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q     <= RX_LO;
      lo_q           <= '0;
      tmo_q          <= '0;
      fir_in_valid_q <= 1'b0;
      fir_in_data_q  <= '0;
      rx_err_q       <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      lo_q           <= lo_d;
      tmo_q          <= tmo_d;
      fir_in_valid_q <= fir_in_valid_d;
      fir_in_data_q  <= fir_in_data_d;
      rx_err_q       <= rx_err_d;
    end
  end

  // Transmit FSM: the GAP states skip the cycle before the transmitter raises busy.
  always_comb begin
    tx_state_d  = tx_state_q;
    word_d      = word_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    last_word_d = last_word_q;
    pop_c       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (level_q != '0) begin
          pop_c      = 1'b1;
          word_d     = mem_q[rd_ptr_q];
          tx_state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (!tx_busy) begin
          tx_data_d  = word_q[7:0];
          tx_start_d = 1'b1;
          tx_state_d = TX_GAP_LO;
        end
      end
      TX_GAP_LO:  tx_state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) tx_state_d = TX_HI;
      TX_HI: begin
        if (!tx_busy) begin
          tx_data_d  = word_q[15:8];
          tx_start_d = 1'b1;
          tx_state_d = TX_GAP_HI;
        end
      end
      TX_GAP_HI:  tx_state_d = TX_WAIT_HI;
      TX_WAIT_HI: begin
        if (!tx_busy) begin
          last_word_d = word_q;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      word_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      last_word_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      word_q      <= word_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      last_word_q <= last_word_d;
    end
  end

  assign fir_in_valid = fir_in_valid_q;
  assign fir_in_data  = fir_in_data_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign ovf          = ovf_q;
  assign rx_err       = rx_err_q;
  assign fifo_level   = level_q;
  assign last_word    = last_word_q;

endmodule

// File: tb/tb_fir_uart_sequencer.sv
// Bench for fir_uart_sequencer: directed steps plus a randomized stretch, all checked
// against a byte/word-level reference model (pending-byte pairing with an age limit, a
// queue of expected transmit bytes, and an arithmetic slice/saturation function).
module tb_fir_uart_sequencer;

  localparam int unsigned RX_TO    = 16;
  localparam int unsigned BUSY_CYC = 10;

  typedef struct packed {
    logic [7:0]  b;
    logic        hi;
    logic [15:0] word;
  } txb_t;

  logic        clk;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        fir_in_valid;
  logic [15:0] fir_in_data;
  logic        fir_out_valid = 1'b0;
  logic [37:0] fir_out_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        ovf;
  logic        rx_err;
  logic [2:0]  fifo_level;
  logic [15:0] last_word;

  fir_uart_sequencer #(
    .OUT_W(38), .SLICE_LSB(8), .FIFO_DEPTH(4), .RX_TIMEOUT(RX_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data),
    .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .ovf(ovf), .rx_err(rx_err),
    .fifo_level(fifo_level), .last_word(last_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit          rx_pend = 0;
  int          rx_age = 0;
  logic [7:0]  rx_lo = '0;
  logic        exp_rx_err = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [15:0] exp_last = '0;
  txb_t        exp_tx[$];
  int          busy_cnt = 0;
  bit          hold_busy = 0;
  bit          lo_sent = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_slice(input logic [37:0] d);
`ifdef FIR_SEQ_SAT_EN
    longint v;
    v = longint'($signed(d));
    v = v >>> 8;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
`else
    return 16'(d >> 8);
`endif
  endfunction

  // One clock: advance transmitter and reference models, then compare.
  task automatic step();
    txb_t       e;
    logic       exp_v;
    logic [15:0] exp_d;
    exp_v = 1'b0;
    exp_d = '0;
    @(posedge clk);
    #1;
    if (prev_start) begin
      check("tx_start_while_busy", 64'(prev_busy), 64'd0);
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL tx_unexpected: observed byte %0h expected none", prev_data);
      end else begin
        e = exp_tx.pop_front();
        check("tx_byte", 64'(prev_data), 64'(e.b));
        if (e.hi) exp_last = e.word;
        lo_sent = !e.hi;
      end
      busy_cnt = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt > 0) || hold_busy;

    if (rst) begin
      rx_pend = 0; rx_age = 0; exp_rx_err = 1'b0; exp_ovf = 1'b0; exp_last = '0;
      exp_tx.delete();
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_fir_in_valid", 64'(fir_in_valid), 64'd0);
      check("rst_fir_in_data", 64'(fir_in_data), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_rx_err", 64'(rx_err), 64'd0);
      check("rst_fifo_level", 64'(fifo_level), 64'd0);
      check("rst_last_word", 64'(last_word), 64'd0);
    end else begin
      if (rx_pend) rx_age++;
      if (rx_ready) begin
        if (rx_pend) begin
          exp_v = 1'b1;
          exp_d = {rx_data, rx_lo};
          rx_pend = 0;
        end else begin
          rx_pend = 1; rx_lo = rx_data; rx_age = 0;
        end
      end else if (rx_pend && rx_age == int'(RX_TO)) begin
        rx_pend = 0;
        exp_rx_err = 1'b1;
      end
      check("fir_in_valid", 64'(fir_in_valid), 64'(exp_v));
      if (exp_v) check("fir_in_data", 64'(fir_in_data), 64'(exp_d));
      check("rx_err", 64'(rx_err), 64'(exp_rx_err));
      check("ovf", 64'(ovf), 64'(exp_ovf));
    end
    prev_start = tx_start;
    prev_data  = tx_data;
    prev_busy  = tx_busy;
    rx_ready      = 1'b0;
    fir_out_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    step();
  endtask

  // Present a FIR result for the next edge; dropped words never reach the wire.
  task automatic queue_word(input logic [37:0] d, input bit drop);
    logic [15:0] w;
    w = ref_slice(d);
    fir_out_valid = 1'b1;
    fir_out_data  = d;
    if (drop) exp_ovf = 1'b1;
    else begin
      exp_tx.push_back(txb_t'{b: w[7:0],  hi: 1'b0, word: w});
      exp_tx.push_back(txb_t'{b: w[15:8], hi: 1'b1, word: w});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy_cnt != 0) && n < 3000) begin
      step();
      n++;
    end
    repeat (4) step();
    check("drain_bound", 64'(n < 3000), 64'd1);
    check("drain_fifo_level", 64'(fifo_level), 64'd0);
    check("drain_last_word", 64'(last_word), 64'(exp_last));
  endtask

  initial begin
    logic [63:0] r64;
    logic [37:0] d;
    logic [15:0] exp_w;
    int          gap;
    int          n;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Byte pair -> one sample
    send_byte(8'h34);
    step();
    send_byte(8'h12);
    check("rx_pair_valid", 64'(fir_in_valid), 64'd1);
    check("rx_pair_data", 64'(fir_in_data), 64'h1234);
    step();
    check("rx_pair_single_pulse", 64'(fir_in_valid), 64'd0);

    // Lone low byte times out, next pair is clean
    send_byte(8'hAA);
    repeat (RX_TO) step();
    check("rx_timeout_err", 64'(rx_err), 64'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    check("rx_after_timeout", 64'(fir_in_data), 64'h0201);

    // Single word out, low byte first
    queue_word(38'h00_00AB_CD00, 1'b0);
    step();
    drain();
`ifdef FIR_SEQ_SAT_EN
    exp_w = 16'h7FFF;
`else
    exp_w = 16'hABCD;
`endif
    check("tx_last_word_abcd", 64'(last_word), 64'(exp_w));

    // Burst of six with transmitter held busy: one in shadow, four queued, one dropped
    hold_busy = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      r64 = {$urandom, $urandom};
      queue_word(38'(r64), i == 5);
      step();
    end
    check("burst_level", 64'(fifo_level), 64'd4);
    check("burst_ovf", 64'(ovf), 64'd1);
    step();
    check("burst_level_hold", 64'(fifo_level), 64'd4);
    hold_busy = 0;
    drain();

    // Slice of out-of-range results
`ifdef FIR_SEQ_SAT_EN
    exp_w = 16'h7FFF;
`else
    exp_w = 16'h0000;
`endif
    queue_word(38'h00_0100_0000, 1'b0);
    step();
    drain();
    check("slice_pos_big", 64'(last_word), 64'(exp_w));
`ifdef FIR_SEQ_SAT_EN
    exp_w = 16'h8000;
`else
    exp_w = 16'h0000;
`endif
    queue_word(38'h3F_FE00_0000, 1'b0);
    step();
    drain();
    check("slice_neg_big", 64'(last_word), 64'(exp_w));

    // Randomized concurrent RX and FIR traffic, kept below FIFO capacity
    gap = 0;
    for (int i = 0; i < 1500; i++) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 99) < 2) gap = 20;
      else if ($urandom_range(0, 3) == 0) begin
        rx_ready = 1'b1;
        rx_data  = 8'($urandom);
      end
      if (exp_tx.size() <= 4 && $urandom_range(0, 39) == 0) begin
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0:       d = 38'(r64);
          1:       d = {{14{r64[23]}}, r64[23:0]};
          default: d = {{20{r64[17]}}, r64[17:0]};
        endcase
        queue_word(d, 1'b0);
      end
      step();
    end
    drain();
    check("ovf_sticky", 64'(ovf), 64'd1);

    // Reset while waiting for the low byte to finish
    lo_sent = 0;
    queue_word(38'h00_0055_6600, 1'b0);
    step();
    n = 0;
    while (!lo_sent && n < 500) begin
      step();
      n++;
    end
    check("lo_sent_bound", 64'(lo_sent), 64'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("tx_start_after_rst", 64'(tx_start), 64'd0);
    repeat (30) step();
    check("rst_fifo_empty", 64'(fifo_level), 64'd0);
    check("rst_last_word_hold", 64'(last_word), 64'd0);
    queue_word(38'h00_0012_3400, 1'b0);
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
